seq_adder_nbit: RTL and testbench

Multi-cycle, parametrised add/subtract unit that generalises the 4-bit ripple full adder to WIDTH bits. It processes CHUNK bits per clock with a registered carry and a start/busy/done handshake, trading latency for a short carry chain. It also adds subtract mode and signed-overflow detection. It sits beside the combinational adders as the datapath arithmetic block for wide operands.

---
 rtl/seq_adder_nbit.sv | 112 +++++++++++
 tb/tb_seq_adder_nbit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_adder_nbit.sv
// Multi-cycle WIDTH-bit add/subtract unit: CHUNK bits per clock through a registered carry,
// with a start/busy/done handshake and signed-overflow detection.
//
// state | meaning
// IDLE  | waiting for start; S/Cout/V hold the last result
// RUN   | adding one chunk per edge, LSB chunk first
module seq_adder_nbit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_bx;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_a_msb;
  logic             r_bx_msb;
  logic [CW-1:0]    r_cnt;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_ext;
  logic [WIDTH-1:0] w_final;

  // Operands shift right each cycle so the active chunk is always the low CHUNK bits;
  // the result fills from the top so it is aligned once the last chunk lands.
  assign {w_cout, w_sum} = (CHUNK+1)'(r_a[CHUNK-1:0]) + (CHUNK+1)'(r_bx[CHUNK-1:0])
                         + (CHUNK+1)'(r_carry);
  assign w_sum_ext = WIDTH'(w_sum) << (WIDTH - CHUNK);
  assign w_final   = (r_res >> CHUNK) | w_sum_ext;
  assign w_last    = (r_cnt == CW'(NCH - 1));
  assign busy      = (r_state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = RUN;
      RUN:     if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_bx     <= '0;
      r_res    <= '0;
      r_carry  <= 1'b0;
      r_a_msb  <= 1'b0;
      r_bx_msb <= 1'b0;
      r_cnt    <= '0;
      done     <= 1'b0;
      S        <= '0;
      Cout     <= 1'b0;
      V        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= A;
            r_bx     <= sub ? ~B : B;
            r_carry  <= sub ? ~Cin : Cin;
            r_a_msb  <= A[WIDTH-1];
            r_bx_msb <= sub ? ~B[WIDTH-1] : B[WIDTH-1];
            r_cnt    <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> CHUNK;
          r_bx    <= r_bx >> CHUNK;
          r_res   <= w_final;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            S    <= w_final;
            Cout <= w_cout;
            V    <= (r_a_msb == r_bx_msb) && (w_final[WIDTH-1] != r_a_msb);
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_adder_nbit.sv
// Bench for seq_adder_nbit: directed and random operations on a 16/4 instance plus a
// parameter sweep (16/16, 16/1, 32/8) checked against an arithmetic reference model.
module tb_seq_adder_nbit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_m = 1'b0;
  logic        start_s = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        cin = 1'b0, sub = 1'b0;

  logic        busy_m, done_m, cout_m, v_m;
  logic [15:0] s_m;
  logic        busy_a, done_a, cout_a, v_a;
  logic [15:0] s_a;
  logic        busy_b, done_b, cout_b, v_b;
  logic [15:0] s_b;
  logic        busy_w, done_w, cout_w, v_w;
  logic [31:0] s_w;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] prev_s = '0;

  always #5 clk = ~clk;

  seq_adder_nbit #(.WIDTH(16), .CHUNK(4)) u_main (
    .clk(clk), .rst(rst), .start(start_m), .A(a16), .B(b16), .Cin(cin), .sub(sub),
    .busy(busy_m), .done(done_m), .S(s_m), .Cout(cout_m), .V(v_m));

  seq_adder_nbit #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst(rst), .start(start_s), .A(a16), .B(b16), .Cin(cin), .sub(sub),
    .busy(busy_a), .done(done_a), .S(s_a), .Cout(cout_a), .V(v_a));

  seq_adder_nbit #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .start(start_s), .A(a16), .B(b16), .Cin(cin), .sub(sub),
    .busy(busy_b), .done(done_b), .S(s_b), .Cout(cout_b), .V(v_b));

  seq_adder_nbit #(.WIDTH(32), .CHUNK(8)) u_w32 (
    .clk(clk), .rst(rst), .start(start_s), .A(a32), .B(b32), .Cin(cin), .sub(sub),
    .busy(busy_w), .done(done_w), .S(s_w), .Cout(cout_w), .V(v_w));

  // Reference: plain integer arithmetic on the unsigned and signed interpretations.
  function automatic void ref_op(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic ci, input logic sb, output logic [63:0] s,
                                 output logic co, output logic v);
    longint ua, ub, c, lim, full, sa, sbv, r;
    ua  = a;
    ub  = b;
    c   = ci ? 64'sd1 : 64'sd0;
    lim = 64'sd1 <<< (w - 1);
    full = sb ? (ua - ub - c + 2 * lim) : (ua + ub + c);
    s   = full & (2 * lim - 1);
    co  = ((full >>> w) & 1) != 0;
    sa  = (ua >= lim) ? ua - 2 * lim : ua;
    sbv = (ub >= lim) ? ub - 2 * lim : ub;
    r   = sb ? (sa - sbv - c) : (sa + sbv + c);
    v   = (r < -lim) || (r > lim - 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts at a falling edge; returns at the falling edge where done is visible.
  task automatic run_main(input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input logic sb, input bit disturb, input string tag);
    logic [63:0] es;
    logic        eco, ev;
    int          n;
    ref_op(16, {48'b0, a}, {48'b0, b}, ci, sb, es, eco, ev);
    a16 = a; b16 = b; cin = ci; sub = sb; start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    n = 0;
    if (disturb) begin
      start_m = 1'b1; a16 = ~a; b16 = a ^ b; cin = ~ci; sub = ~sb;
    end
    while (done_m !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      start_m = 1'b0;
      if (n == 2) chk({tag, "_hold"}, {48'b0, s_m}, {48'b0, prev_s});
    end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_busy"}, {63'b0, busy_m}, 0);
    chk({tag, "_S"}, {48'b0, s_m}, es);
    chk({tag, "_Cout"}, {63'b0, cout_m}, {63'b0, eco});
    chk({tag, "_V"}, {63'b0, v_m}, {63'b0, ev});
    prev_s = es[15:0];
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, "_done_low"}, {63'b0, done_m}, 0);
    chk({tag, "_idle"}, {63'b0, busy_m}, 0);
  endtask

  task automatic run_sweep(input string tag);
    logic [63:0] e16, e32;
    logic        eco16, ev16, eco32, ev32;
    logic [15:0] ca, cb;
    logic [31:0] cw;
    logic        coa, cob, cow, va, vb, vw;
    int          la, lb, lw, n;
    a16 = 16'($urandom); b16 = 16'($urandom);
    a32 = $urandom; b32 = $urandom;
    cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    ref_op(16, {48'b0, a16}, {48'b0, b16}, cin, sub, e16, eco16, ev16);
    ref_op(32, {32'b0, a32}, {32'b0, b32}, cin, sub, e32, eco32, ev32);
    la = -1; lb = -1; lw = -1;
    ca = '0; cb = '0; cw = '0; coa = 0; cob = 0; cow = 0; va = 0; vb = 0; vw = 0;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    n = 0;
    while ((la < 0 || lb < 0 || lw < 0) && n < 40) begin
      @(negedge clk);
      n++;
      if (done_a === 1'b1 && la < 0) begin la = n; ca = s_a; coa = cout_a; va = v_a; end
      if (done_b === 1'b1 && lb < 0) begin lb = n; cb = s_b; cob = cout_b; vb = v_b; end
      if (done_w === 1'b1 && lw < 0) begin lw = n; cw = s_w; cow = cout_w; vw = v_w; end
    end
    chk({tag, "_c16_lat"}, la, 1);
    chk({tag, "_c16_res"}, {47'b0, coa, ca, va}, {47'b0, eco16, e16[15:0], ev16});
    chk({tag, "_c1_lat"}, lb, 16);
    chk({tag, "_c1_res"}, {47'b0, cob, cb, vb}, {47'b0, eco16, e16[15:0], ev16});
    chk({tag, "_w32_lat"}, lw, 4);
    chk({tag, "_w32_res"}, {31'b0, cow, cw, vw}, {31'b0, eco32, e32[31:0], ev32});
  endtask

  initial begin
    int ndone;
    repeat (2) @(negedge clk);
    chk("rst_init", {44'b0, busy_m, done_m, s_m, cout_m, v_m}, 0);
    rst = 1'b0;

    run_main(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, "add_basic");
    idle_check("add_basic");
    run_main(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, "ripple");
    run_main(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, "b2b_ovf");
    idle_check("b2b_ovf");
    run_main(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, "sub_borrow");
    idle_check("sub_borrow");
    run_main(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, "sub_ovf");
    idle_check("sub_ovf");
    run_main(16'h1234, 16'h0F0F, 1'b0, 1'b0, 1'b1, "busy_start");
    repeat (3) idle_check("busy_start_ignored");

    for (int i = 0; i < 8; i++) begin
      run_main(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand_main");
    end
    idle_check("rand_main");

    run_main(16'h00F0, 16'h0F00, 1'b0, 1'b0, 1'b0, "pre_rst");
    a16 = 16'h4444; b16 = 16'h1111; cin = 1'b0; sub = 1'b0; start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_busy", {63'b0, busy_m}, 0);
    chk("rst_async_done", {63'b0, done_m}, 0);
    chk("rst_async_out", {46'b0, s_m, cout_m, v_m}, 0);
    @(negedge clk);
    rst = 1'b0;
    prev_s = '0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_m === 1'b1) ndone++;
    end
    chk("rst_abort_no_done", ndone, 0);
    chk("rst_abort_S", {48'b0, s_m}, 0);

    run_main(16'hA5A5, 16'h5A5B, 1'b1, 1'b1, 1'b0, "post_rst");
    idle_check("post_rst");

    for (int i = 0; i < 12; i++) run_sweep("sweep");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
